// File: rtl/pipe_stage_chain.sv
// Chain of STAGES valid/ready pipeline registers with per-stage kill, global flush and occupancy.
// Optional PIPE_STATS_EN adds saturating stall/bubble counters at the output port.
module pipe_stage_chain #(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 4,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    input  logic [STAGES-1:0]   kill_mask,
    input  logic                flush,
    output logic [STAGES-1:0]   stage_valid,
    output logic [OCC_W-1:0]    occupancy
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
`endif
);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];

    logic [STAGES-1:0] w_ev;
    logic [STAGES:0]   w_rdy;
    logic              w_in_fire;
    logic [STAGES-1:0] w_src_v;
    logic [WIDTH-1:0]  w_src_d [STAGES];
    logic [OCC_W-1:0]  w_occ;

    assign w_ev = r_valid & ~kill_mask & {STAGES{~flush}};

    // Ready ripples from the output back to the input; a killed or empty stage is always ready.
    always_comb begin : ready_chain
        logic w_acc;
        w_acc = out_ready;
        w_rdy = '0;
        w_rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc    = ~w_ev[i] | w_acc;
            w_rdy[i] = w_acc;
        end
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign w_in_fire = in_valid & in_ready;

    always_comb begin
        w_src_v    = '0;
        w_src_v[0] = w_in_fire;
        w_src_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            w_src_v[i] = w_ev[i-1];
            w_src_d[i] = r_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_src_v[i] && w_rdy[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= w_src_d[i];
                end else if (w_rdy[i+1]) begin
                    r_valid[i] <= 1'b0;
                end else begin
                    r_valid[i] <= w_ev[i];
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) w_occ = w_occ + OCC_W'(r_valid[i]);
    end

    assign out_valid   = w_ev[STAGES-1];
    assign out_data    = r_data[STAGES-1];
    assign stage_valid = r_valid;
    assign occupancy   = w_occ;

`ifdef PIPE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!out_valid && out_ready && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=32, STAGES=4): streaming, backpressure,
// bubble collapse, kill, flush and mid-stream reset with hand-computed expectations.
module tb_pipe_stage_chain;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [STAGES-1:0] kill_mask;
    logic              flush;
    logic [STAGES-1:0] stage_valid;
    logic [2:0]        occupancy;
`ifdef PIPE_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int n_chk;
    int n_err;

    pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .kill_mask   (kill_mask),
        .flush       (flush),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n consecutive words starting at base, one per edge, into an empty chain.
    task automatic fill(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(base + k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int nout;
        n_chk     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        kill_mask = '0;
        flush     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_stage_valid", 32'(stage_valid), 32'h0);
        chk("rst_occupancy",   32'(occupancy),   32'h0);
        chk("rst_out_valid",   32'(out_valid),   32'h0);
        chk("rst_out_data",    out_data,         32'h0);
        chk("rst_in_ready",    32'(in_ready),    32'h1);

        // Streaming: 0x11..0x18 back-to-back, outputs after edges 3..10.
        out_ready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            in_valid = (e < 8);
            in_data  = 32'(32'h11 + e);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            tick();
            chk("stream_out_valid", 32'(out_valid), ((e >= 3) && (e <= 10)) ? 32'h1 : 32'h0);
            if ((e >= 3) && (e <= 10))
                chk("stream_out_data", out_data, 32'(32'h11 + e - 3));
        end
        in_valid = 1'b0;

        // Backpressure: offer 6 words with out_ready=0, only 4 fit.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h21 + idx);
            #1;
            chk("bp_in_ready", 32'(in_ready), (c < 4) ? 32'h1 : 32'h0);
            if (in_ready) idx++;
            tick();
        end
        chk("bp_accepted",    32'(idx),         32'h4);
        chk("bp_occupancy",   32'(occupancy),   32'h4);
        chk("bp_stage_valid", 32'(stage_valid), 32'hF);
        chk("bp_out_data",    out_data,         32'h21);
        out_ready = 1'b1;
        nout = 0;
        for (int c = 0; c < 20 && nout < 6; c++) begin
            in_valid = (idx < 6);
            in_data  = 32'(32'h21 + idx);
            #1;
            if (out_valid) begin
                chk("drain_data", out_data, 32'(32'h21 + nout));
                nout++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        chk("drain_count", 32'(nout), 32'h6);
        tick();
        tick();
        chk("drain_empty", 32'(occupancy), 32'h0);

        // Bubble collapse: A, two idle cycles, B, output stalled.
        out_ready = 1'b0;
        fill(32'hA, 1);
        tick();
        tick();
        fill(32'hB, 1);
        tick();
        tick();
        chk("bub_stage_valid", 32'(stage_valid), 32'hC);
        chk("bub_occupancy",   32'(occupancy),   32'h2);
        chk("bub_out_data",    out_data,         32'hA);
        out_ready = 1'b1;
        tick();
        chk("bub_next_data", out_data, 32'hB);
        tick();
        chk("bub_empty", 32'(occupancy), 32'h0);

        // Kill: A B C D, squash stages 0 and 1.
        out_ready = 1'b0;
        fill(32'h41, 4);
        chk("kill_full", 32'(stage_valid), 32'hF);
        out_ready = 1'b1;
        kill_mask = 4'b0011;
        #1;
        chk("kill_out_a", out_data, 32'h41);
        tick();
        kill_mask = '0;
        chk("kill_stage_valid", 32'(stage_valid), 32'h8);
        chk("kill_out_b",       out_data,         32'h42);
        tick();
        chk("kill_occ_zero", 32'(occupancy), 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("kill_no_cd", 32'(out_valid), 32'h0);
            tick();
        end

        // Flush a full chain while offering 0xDEAD.
        out_ready = 1'b0;
        fill(32'h51, 4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        #1;
        chk("flush_in_ready",  32'(in_ready),  32'h0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occupancy",   32'(occupancy),   32'h0);
        chk("flush_stage_valid", 32'(stage_valid), 32'h0);
`ifdef PIPE_STATS_EN
        chk("flush_stall_cnt",  stall_cnt,  32'h0);
        chk("flush_bubble_cnt", bubble_cnt, 32'h0);
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("flush_no_dead", 32'(out_valid), 32'h0);
            tick();
        end
`ifdef PIPE_STATS_EN
        chk("bubble_cnt_6", bubble_cnt, 32'h6);
`endif

        // Reset mid-stream with 3 live entries after 10 stalled cycles.
        out_ready = 1'b0;
        fill(32'h61, 3);
        tick();
        for (int c = 0; c < 10; c++) tick();
        chk("pre_rst_occupancy",   32'(occupancy),   32'h3);
        chk("pre_rst_stage_valid", 32'(stage_valid), 32'hE);
`ifdef PIPE_STATS_EN
        chk("stall_cnt_10", stall_cnt, 32'hA);
`endif
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("mid_rst_stage_valid", 32'(stage_valid), 32'h0);
        chk("mid_rst_occupancy",   32'(occupancy),   32'h0);
        chk("mid_rst_out_valid",   32'(out_valid),   32'h0);
        chk("mid_rst_out_data",    out_data,         32'h0);
`ifdef PIPE_STATS_EN
        chk("mid_rst_stall_cnt", stall_cnt, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
